sop_share_eval: RTL and testbench
=================================

SOP_SHARE_EVAL -- requirements
Module: sop_share_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning input bit count (even, at least 2).
REQ-002 SHALL have parameter N_OUT, default 3, meaning output bit count; SHALL equal N_IN/2+1.
REQ-003 SHALL have parameter N_PROD, default 2, meaning number of shared product terms.
REQ-004 SHALL have parameter ET, default 3, meaning error threshold (absolute).
REQ-005 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-006 SHALL have ports:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  cfg_valid  in  1  config write request
  cfg_ready  out  1  config write accept
  cfg_addr  in  clog2(N_PROD+N_OUT+2)  config register index
  cfg_data  in  max(2*N_IN,N_PROD,N_OUT)  config payload
  cfg_err  out  1  sticky bad-address flag
  in_valid / in_ready  in / out  1  operand handshake
  in_data  in  N_IN  {B,A}, A = low N_IN/2 bits
  out_valid / out_ready  out / in  1  result handshake
  out_data  out  N_OUT  approximate sum
  out_err  out  1  |out_data - (A+B)| > ET
  cnt_clr  in  1  synchronous clear of counters
  sample_cnt, err_cnt  out  CNT_W  results delivered / results with out_err
REQ-007 Clock port SHALL be clk; reset port SHALL be rst_n, asynchronous, active-low.

Function
REQ-008 Config map: addr p<N_PROD = product p, data {neg_mask[N_IN], pos_mask[N_IN]}; addr N_PROD+o = output o product-select mask [N_PROD]; addr N_PROD+N_OUT = output-enable mask [N_OUT]; addr N_PROD+N_OUT+1 = commit (data ignored).
REQ-009 Product p SHALL be AND of in_data[i] (pos_mask[i]=1) and ~in_data[i] (neg_mask[i]=1); all-zero masks yield constant 1; pos and neg set for same i yield constant 0.
REQ-010 Output o SHALL be OR of selected products, forced 0 if select mask is zero or enable bit o is 0.
REQ-011 States: CFG, RUN, DRAIN. CFG: cfg_ready=1, in_ready=0. Commit write moves CFG->RUN.
REQ-012 RUN: cfg_ready=0; a cfg_valid in RUN SHALL move to DRAIN. DRAIN: in_ready=0, cfg_ready=0, until both pipeline stages are empty, then CFG.
REQ-013 Pipeline SHALL be 2 stages (S1: registered products and exact sum; S2: registered outputs and out_err); latency in accept -> out_valid = 2 cycles.
REQ-014 Stage advances when downstream stage is empty or being consumed; in_ready in RUN = !S1_valid || S1 advancing; full throughput of 1 result/cycle with out_ready=1.
REQ-015 out_data/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 Exact sum A+B SHALL be N_OUT bits; difference SHALL be computed unsigned-absolute in N_OUT+1 bits.
REQ-017 sample_cnt increments on each out_valid&out_ready; err_cnt also when out_err=1; both saturate at all-ones; cnt_clr has priority over increment in the same cycle.
REQ-018 Write with addr > N_PROD+N_OUT+1 SHALL be ignored and set cfg_err; cfg_err clears only on reset.
REQ-019 Config registers SHALL NOT change while state is RUN or DRAIN.

Reset
REQ-020 Reset SHALL give state CFG, all masks 0, out_valid=0, in_ready=0, cfg_ready=1, out_data=0, out_err=0, counters 0, cfg_err=0.
REQ-021 Reset mid-operation SHALL discard in-flight results without incrementing counters.

Structure
REQ-022 Package sop_share_pkg SHALL hold the state enum and address-offset functions (prod, sel, enable, commit).
REQ-023 Sub-module sop_abs_diff SHALL compute the error compare, instantiated once in S2.

Verification
REQ-024 Defaults; product0 pos=4'b1100, product1 masks 0, sel0=2'b11, sel1=2'b10, sel2=0, enable=3'b011, commit; sweep in_data 0..15 -> every out_data=3'b011, out_err=0, sample_cnt=16, err_cnt=0.
REQ-025 Enable=3'b000, commit; in_data=4'b1111 -> out_data=0, out_err=1 (6>3); in_data=4'b0101 -> out_err=0 (2<=3).
REQ-026 out_ready held 0 for 5 cycles with 3 inputs offered -> only 2 accepted, outputs stable, none lost or duplicated after release.
REQ-027 cfg_valid in RUN with 2 in flight -> in_ready drops next cycle, both results delivered, then cfg_ready=1.
REQ-028 cfg_addr=7 (defaults) -> cfg_err=1, no register change; rst_n low mid-stream -> out_valid=0, counters 0 immediately.

Source files
------------

// File: rtl/sop_share_pkg.sv
// Shared types and config-map helpers for the sum-of-products approximate adder evaluator.
package sop_share_pkg;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Config register map: products first, then per-output selects, enable, commit.
  function automatic int unsigned prod_addr(input int unsigned p);
    return p;
  endfunction

  function automatic int unsigned sel_addr(input int unsigned n_prod, input int unsigned o);
    return n_prod + o;
  endfunction

  function automatic int unsigned enable_addr(input int unsigned n_prod, input int unsigned n_out);
    return n_prod + n_out;
  endfunction

  function automatic int unsigned commit_addr(input int unsigned n_prod, input int unsigned n_out);
    return n_prod + n_out + 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sop_abs_diff.sv
// Unsigned absolute difference of two W-bit values in W+1 bits, flagged against a threshold.
module sop_abs_diff #(
  parameter int unsigned W  = 3,
  parameter int unsigned ET = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt_c
);

  localparam int unsigned DW = W + 1;

  logic [DW-1:0] ax;
  logic [DW-1:0] bx;
  logic [DW-1:0] diff;

  assign ax   = DW'(a);
  assign bx   = DW'(b);
  assign diff = (ax >= bx) ? (ax - bx) : (bx - ax);
  assign gt_c = diff > DW'(ET);

endmodule

// File: rtl/sop_share_eval.sv
// Configurable shared-product SOP approximate adder with a 2-stage pipeline,
// error flagging against the exact sum, and delivery/error statistics.
module sop_share_eval
  import sop_share_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned N_PROD = 2,
  parameter int unsigned ET     = 3,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned ADDR_W = $clog2(N_PROD + N_OUT + 2),
  localparam int unsigned CFG_W  = max3(2 * N_IN, N_PROD, N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  output logic              out_err,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned HALF = N_IN / 2;

  state_e state_q, state_d;

  logic [N_IN-1:0]   pos_mask [N_PROD];
  logic [N_IN-1:0]   neg_mask [N_PROD];
  logic [N_PROD-1:0] sel_mask [N_OUT];
  logic [N_OUT-1:0]  en_mask;

  logic              s1_valid;
  logic [N_PROD-1:0] s1_prod;
  logic [N_OUT-1:0]  s1_sum;

  int unsigned       addr_c;
  logic              cfg_wr_c;
  logic              s2_adv_c;
  logic              accept_c;
  logic              hs_c;
  logic [N_PROD-1:0] prod_c;
  logic [N_OUT-1:0]  sum_c;
  logic [N_OUT-1:0]  approx_c;
  logic              err_c;

  assign addr_c   = 32'(cfg_addr);
  assign cfg_wr_c = cfg_valid && (state_q == ST_CFG);
  assign s2_adv_c = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign hs_c     = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CFG;
    else        state_q <= state_d;
  end

  // Next state and handshake readiness.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      ST_CFG: begin
        cfg_ready = 1'b1;
        if (cfg_valid && addr_c == commit_addr(N_PROD, N_OUT)) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = !s1_valid || s2_adv_c;
        if (cfg_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid && !out_valid) state_d = ST_CFG;
      end
      default: state_d = ST_CFG;
    endcase
  end

  // Config registers: written only while configuring; out-of-map writes are sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < N_PROD; p++) begin
        pos_mask[p] <= '0;
        neg_mask[p] <= '0;
      end
      for (int unsigned o = 0; o < N_OUT; o++) sel_mask[o] <= '0;
      en_mask <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_wr_c) begin
      for (int unsigned p = 0; p < N_PROD; p++) begin
        if (addr_c == prod_addr(p)) begin
          pos_mask[p] <= cfg_data[N_IN-1:0];
          neg_mask[p] <= cfg_data[2*N_IN-1:N_IN];
        end
      end
      for (int unsigned o = 0; o < N_OUT; o++) begin
        if (addr_c == sel_addr(N_PROD, o)) sel_mask[o] <= cfg_data[N_PROD-1:0];
      end
      if (addr_c == enable_addr(N_PROD, N_OUT)) en_mask <= cfg_data[N_OUT-1:0];
      if (addr_c > commit_addr(N_PROD, N_OUT)) cfg_err <= 1'b1;
    end
  end

  // Shared product terms; a bit set in both masks makes the term unsatisfiable.
  always_comb begin
    prod_c = '0;
    for (int unsigned p = 0; p < N_PROD; p++) begin
      prod_c[p] = &((in_data | ~pos_mask[p]) & (~in_data | ~neg_mask[p]));
    end
  end

  assign sum_c = N_OUT'(in_data[HALF-1:0]) + N_OUT'(in_data[N_IN-1:HALF]);

  always_comb begin
    approx_c = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      approx_c[o] = en_mask[o] & (|(sel_mask[o] & s1_prod));
    end
  end

  sop_abs_diff #(
    .W  (N_OUT),
    .ET (ET)
  ) u_abs_diff (
    .a    (approx_c),
    .b    (s1_sum),
    .gt_c (err_c)
  );

  // Stage 1: products and exact sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_sum   <= '0;
    end else if (!s1_valid || s2_adv_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_prod <= prod_c;
        s1_sum  <= sum_c;
      end
    end
  end

  // Stage 2: approximate outputs and error flag, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= approx_c;
        out_err  <= err_c;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (cnt_clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (hs_c) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
      if (out_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sop_share_eval.sv
// Directed bench for sop_share_eval with a behavioural SOP/error/counter model and per-cycle compare.
module tb_sop_share_eval;

  localparam int ET_TB  = 3;
  localparam int CNT_MX = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_data;
  logic        out_err;
  logic        cnt_clr;
  logic [15:0] sample_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] pos_m [2];
  logic [3:0] neg_m [2];
  logic [1:0] sel_m [3];
  logic [2:0] en_m;

  logic [3:0] exp_q [$];
  logic [3:0] stim_q [$];
  int         exp_s = 0;
  int         exp_e = 0;
  bit         prev_stall = 0;
  logic [2:0] prev_data;
  logic       prev_err;
  logic [2:0] last_data;
  logic       last_err;

  sop_share_eval dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .cnt_clr    (cnt_clr),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {out_data, out_err} straight from the SOP and error-threshold rules.
  function automatic logic [3:0] model_eval(input logic [3:0] d);
    int sum, outv, diff;
    bit hit, pt;
    sum  = int'(d[1:0]) + int'(d[3:2]);
    outv = 0;
    for (int o = 0; o < 3; o++) begin
      hit = 0;
      for (int p = 0; p < 2; p++) begin
        pt = 1;
        for (int i = 0; i < 4; i++) begin
          if (pos_m[p][i] && !d[i]) pt = 0;
          if (neg_m[p][i] && d[i]) pt = 0;
        end
        if (sel_m[o][p] && pt) hit = 1;
      end
      if (en_m[o] && hit) outv += 1 << o;
    end
    diff = (outv > sum) ? outv - sum : sum - outv;
    return {3'(outv), diff > ET_TB};
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      pos_m[p] = '0;
      neg_m[p] = '0;
    end
    for (int o = 0; o < 3; o++) sel_m[o] = '0;
    en_m = '0;
  endtask

  // Per-cycle compare: scoreboard, hold-while-stalled, and counter model.
  always @(negedge clk) begin
    logic [3:0] e;
    bit hs;
    if (!rst_n) begin
      exp_q.delete();
      exp_s = 0;
      exp_e = 0;
      prev_stall = 0;
    end else begin
      check("sample_cnt", 32'(sample_cnt), 32'(exp_s));
      check("err_cnt", 32'(err_cnt), 32'(exp_e));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      hs = out_valid && out_ready;
      e  = '0;
      if (exp_q.size() == 0) begin
        check("no_extra_out", 32'(hs), 32'd0);
      end else if (hs) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[3:1]));
        check("out_err", 32'(out_err), 32'(e[0]));
        last_data = out_data;
        last_err  = out_err;
      end
      if (cnt_clr) begin
        exp_s = 0;
        exp_e = 0;
      end else if (hs) begin
        if (exp_s != CNT_MX) exp_s++;
        if (e[0] && exp_e != CNT_MX) exp_e++;
      end
      if (in_valid && in_ready) exp_q.push_back(model_eval(in_data));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input int a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = 3'(a);
    cfg_data  = d;
    @(negedge clk);
    check("cfg_ready_wr", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (a < 2) begin
      pos_m[a] = d[3:0];
      neg_m[a] = d[7:4];
    end else if (a < 5) begin
      sel_m[a-2] = d[1:0];
    end else if (a == 5) begin
      en_m = d[2:0];
    end
  endtask

  task automatic send(input int stall, output int acc_stall);
    int idx, cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    acc_stall = 0;
    while (idx < stim_q.size() && cyc < 1000) begin
      out_ready = (cyc >= stall);
      in_valid  = 1'b1;
      in_data   = stim_q[idx];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (cyc < stall) acc_stall++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("send_done", 32'(idx), 32'(stim_q.size()));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic to_cfg();
    int n;
    cfg_valid = 1'b1;
    cfg_addr  = 3'd0;
    cfg_data  = 8'hFF;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("in_ready_drain", 32'(in_ready), 32'd0);
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("back_to_cfg", 32'(cfg_ready), 32'd1);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_counts", 32'({sample_cnt, err_cnt}), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;

    // Constant-3 approximation over the full input range.
    cfg_write(0, 8'h0C); cfg_write(1, 8'h00); cfg_write(2, 8'h03);
    cfg_write(3, 8'h02); cfg_write(4, 8'h00); cfg_write(5, 8'h03);
    check("model_sweep_0", 32'(model_eval(4'h0)), 32'h6);
    check("model_sweep_f", 32'(model_eval(4'hF)), 32'h6);
    cfg_write(6, 8'h00);
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(4'(i));
    send(0, acc);
    wait_drain();
    check("sweep_samples", 32'(sample_cnt), 32'd16);
    check("sweep_errs", 32'(err_cnt), 32'd0);
    check("sweep_last", 32'(last_data), 32'd3);
    to_cfg();

    // All outputs disabled: error depends only on the exact sum.
    cfg_write(5, 8'h00);
    check("model_dis_f", 32'(model_eval(4'hF)), 32'h1);
    check("model_dis_5", 32'(model_eval(4'h5)), 32'h0);
    cfg_write(6, 8'h00);
    stim_q.delete();
    stim_q.push_back(4'hF);
    stim_q.push_back(4'h5);
    send(0, acc);
    wait_drain();
    check("dis_last_err", 32'(last_err), 32'd0);
    to_cfg();

    // Mixed-polarity products with shared selects; backpressure.
    cfg_write(0, 8'h21); cfg_write(1, 8'h08); cfg_write(2, 8'h01);
    cfg_write(3, 8'h02); cfg_write(4, 8'h03); cfg_write(5, 8'h07);
    check("model_mix_1", 32'(model_eval(4'h1)), 32'hB);
    check("model_mix_8", 32'(model_eval(4'h8)), 32'hD);
    check("model_mix_f", 32'(model_eval(4'hF)), 32'hC);
    cfg_write(6, 8'h00);
    stim_q.delete();
    stim_q.push_back(4'h1);
    stim_q.push_back(4'h8);
    stim_q.push_back(4'h9);
    send(5, acc);
    check("stall_accepts", 32'(acc), 32'd2);
    wait_drain();

    // Config request with two results in flight.
    stim_q.delete();
    stim_q.push_back(4'h0);
    stim_q.push_back(4'hF);
    send(0, acc);
    to_cfg();

    // Out-of-map write leaves config untouched.
    check("cfg_err_before", 32'(cfg_err), 32'd0);
    cfg_write(7, 8'hFF);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    cfg_write(6, 8'h00);
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(4'(i * 2 + 1));
    send(0, acc);
    wait_drain();
    check("cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Clear coinciding with a delivery, then reset mid-stream.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 4'(i + 9);
      cnt_clr = (i == 2);
      @(posedge clk); #1;
    end
    cnt_clr = 1'b0;
    check("clr_then_one", 32'(sample_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_samples", 32'(sample_cnt), 32'd0);
    check("midrst_errs", 32'(err_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    in_valid = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_cfg_err", 32'(cfg_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
